// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the L1D<->memory line-transfer responder:
// FSM state codes, beat indexing and address slicing.
package mem_if_pkg;

    localparam int unsigned MEM_BEATS  = 4;
    localparam int unsigned MEM_BEAT_W = $clog2(MEM_BEATS);

    typedef logic [MEM_BEAT_W-1:0] beat_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RD   = 2'd2;
    localparam state_t ST_WR   = 2'd3;

    // Byte address -> word index, wrapped to the backing-store depth.
    function automatic logic [31:0] addr_word_index(input logic [31:0] addr,
                                                    input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

    function automatic logic [31:0] addr_line_base(input logic [31:0] word_idx,
                                                   input int unsigned beat_w);
        return word_idx & ~((32'd1 << beat_w) - 32'd1);
    endfunction

    // Position of the requested word within its line.
    function automatic logic [31:0] addr_word_in_line(input logic [31:0] addr,
                                                      input int unsigned beat_w);
        return (addr >> 2) & ((32'd1 << beat_w) - 32'd1);
    endfunction

    function automatic logic [31:0] beat_onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous RAM backing the line responder.
// Read data is registered; contents are never reset.
module mem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: accepts a line address, then serves a BEATS-word
// refill (LOAD) or absorbs a BEATS-word writeback (STORE).
// Optional: CRITICAL_WORD_FIRST_EN starts refills at the requested word.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for an address phase
// WAIT    | access latency countdown before the first beat
// RD      | driving refill beats, advancing on matching ack
// WR      | committing write beats on VALID
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BEATS       = MEM_BEATS,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD,
    input  logic              STORE,
    input  logic              VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [BEATS-1:0]  ACK_DATA_L1,
    output logic              ACK_ADDR,
    output logic              READY,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE,
    output logic [BEATS-1:0]  ACK_DATA_MEM,
    output logic              ERR
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] done_q;
    logic [BEAT_W-1:0] beat_nxt;
    logic [BEAT_W-1:0] start_beat;
    logic [BEATS-1:0]  beat_oh;
    logic [IDX_W-1:0]  line_base;
    logic [IDX_W-1:0]  ram_addr;
    logic              ram_we;
    logic              ack_hit;
    logic [DATA_W-1:0] ram_rdata;

    assign line_base = IDX_W'(addr_line_base(addr_word_index(32'(addr_q), IDX_W), BEAT_W));
    assign beat_nxt  = beat_q + 1'b1;
    assign beat_oh   = BEATS'(beat_onehot(32'(beat_q)));
    assign ack_hit   = |(ACK_DATA_L1 & beat_oh);

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_beat = BEAT_W'(addr_word_in_line(32'(addr_q), BEAT_W));
`else
    assign start_beat = '0;
`endif

    // The RAM read is registered, so the address for the next visible beat
    // is presented one cycle ahead: the start beat during WAIT, the following
    // beat in the same cycle an ack lands in RD.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = line_base | IDX_W'(beat_q);
        case (state_q)
            ST_WAIT: ram_addr = line_base | IDX_W'(start_beat);
            ST_RD: begin
                if (ack_hit) begin
                    ram_addr = line_base | IDX_W'(beat_nxt);
                end
            end
            ST_WR:   ram_we = VALID;
            default: ram_we = 1'b0;
        endcase
    end

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (DATA_IN),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            done_q       <= '0;
            ACK_ADDR     <= 1'b0;
            ERR          <= 1'b0;
            ACK_DATA_MEM <= '0;
        end else begin
            ACK_ADDR     <= 1'b0;
            ERR          <= 1'b0;
            ACK_DATA_MEM <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (VALID) begin
                        if (LOAD && STORE) begin
                            ERR <= 1'b1;
                        end else if (LOAD) begin
                            addr_q   <= ADDR_W'(DATA_IN);
                            ACK_ADDR <= 1'b1;
                            cnt_q    <= CNT_W'(LATENCY - 1);
                            state_q  <= ST_WAIT;
                        end else if (STORE) begin
                            addr_q   <= ADDR_W'(DATA_IN);
                            ACK_ADDR <= 1'b1;
                            beat_q   <= '0;
                            state_q  <= ST_WR;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        beat_q  <= start_beat;
                        done_q  <= '0;
                        state_q <= ST_RD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RD: begin
                    if (ack_hit) begin
                        beat_q <= beat_nxt;
                        done_q <= done_q + 1'b1;
                        if (done_q == BEAT_W'(BEATS - 1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WR: begin
                    if (VALID) begin
                        ACK_DATA_MEM <= beat_oh;
                        beat_q       <= beat_nxt;
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign READY    = (state_q == ST_RD);
    assign DATA_OE  = READY;
    assign DATA_OUT = READY ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed scenarios plus
// randomized loads/stores against a word-array reference model.
module tb_mem_line_responder;

    localparam int LAT   = 3;
    localparam int NBEAT = 4;
    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LOAD = 1'b0;
    logic        STORE = 1'b0;
    logic        VALID = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic [3:0]  ACK_DATA_L1 = '0;
    logic        ACK_ADDR;
    logic        READY;
    logic [31:0] DATA_OUT;
    logic        DATA_OE;
    logic [3:0]  ACK_DATA_MEM;
    logic        ERR;

    logic [31:0] ref_mem [DEPTH];
    bit          line_valid [DEPTH/NBEAT];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 CLK = ~CLK;

    mem_line_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .BEATS       (NBEAT),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .LOAD         (LOAD),
        .STORE        (STORE),
        .VALID        (VALID),
        .DATA_IN      (DATA_IN),
        .ACK_DATA_L1  (ACK_DATA_L1),
        .ACK_ADDR     (ACK_ADDR),
        .READY        (READY),
        .DATA_OUT     (DATA_OUT),
        .DATA_OE      (DATA_OE),
        .ACK_DATA_MEM (ACK_DATA_MEM),
        .ERR          (ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr(input int line);
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_F000) | (32'(line) << 4)
            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    // mode 0: ack at once; 1: random stalls with stray acks; 2: beat 1 stalled 3 cycles
    task automatic do_load(input logic [31:0] addr, input int mode, input int abort_at);
        int base, start, beat, stall;
        logic [3:0] oh;
        base = widx(addr) & ~3;
`ifdef CRITICAL_WORD_FIRST_EN
        start = widx(addr) & 3;
`else
        start = 0;
`endif
        VALID = 1'b1; LOAD = 1'b1; STORE = 1'b0; DATA_IN = addr;
        @(negedge CLK);
        VALID = 1'b0; LOAD = 1'b0; DATA_IN = $urandom;
        chk("ld_ack_addr", 32'(ACK_ADDR), 32'd1);
        chk("ld_ready_early", 32'(READY), 32'd0);
        for (int c = 2; c <= LAT; c++) begin
            @(negedge CLK);
            chk("ld_wait_ready", 32'(READY), 32'd0);
            chk("ld_ack_addr_once", 32'(ACK_ADDR), 32'd0);
        end
        @(negedge CLK);
        for (int i = 0; i < NBEAT; i++) begin
            if (i == abort_at) begin
                RST_N = 1'b0;
                ACK_DATA_L1 = '0;
                #1;
                chk("rst_ready", 32'(READY), 32'd0);
                chk("rst_oe", 32'(DATA_OE), 32'd0);
                chk("rst_data", DATA_OUT, 32'd0);
                chk("rst_ack_addr", 32'(ACK_ADDR), 32'd0);
                chk("rst_err", 32'(ERR), 32'd0);
                @(negedge CLK);
                chk("rst_hold_ready", 32'(READY), 32'd0);
                RST_N = 1'b1;
                return;
            end
            beat = (start + i) % NBEAT;
            oh = 4'(1 << beat);
            if (mode == 0) stall = 0;
            else if (mode == 1) stall = int'($urandom_range(0, 3));
            else stall = (i == 1) ? 3 : 0;
            for (int s = 0; s <= stall; s++) begin
                chk("ld_ready", 32'(READY), 32'd1);
                chk("ld_oe", 32'(DATA_OE), 32'd1);
                chk("ld_data", DATA_OUT, ref_mem[base + beat]);
                if (s == stall) ACK_DATA_L1 = oh;
                else if (mode == 2) ACK_DATA_L1 = 4'b1000;
                else ACK_DATA_L1 = 4'($urandom) & ~oh;
                @(negedge CLK);
            end
        end
        ACK_DATA_L1 = '0;
        chk("ld_ready_end", 32'(READY), 32'd0);
        chk("ld_oe_end", 32'(DATA_OE), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [127:0] d, input bit gaps);
        int base;
        base = widx(addr) & ~3;
        VALID = 1'b1; STORE = 1'b1; LOAD = 1'b0; DATA_IN = addr;
        @(negedge CLK);
        chk("st_ack_addr", 32'(ACK_ADDR), 32'd1);
        chk("st_ackmem_first", 32'(ACK_DATA_MEM), 32'd0);
        for (int b = 0; b < NBEAT; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    VALID = 1'b0; LOAD = 1'($urandom); STORE = 1'($urandom); DATA_IN = $urandom;
                    @(negedge CLK);
                    chk("st_gap_ack", 32'(ACK_DATA_MEM), 32'd0);
                end
            end
            VALID = 1'b1;
            DATA_IN = d[b*32 +: 32];
            LOAD = gaps ? 1'($urandom) : 1'b0;
            STORE = gaps ? 1'($urandom) : 1'b1;
            @(negedge CLK);
            chk("st_ack_mem", 32'(ACK_DATA_MEM), 32'd1 << b);
            chk("st_ready", 32'(READY), 32'd0);
            ref_mem[base + b] = d[b*32 +: 32];
        end
        VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0;
        line_valid[base / NBEAT] = 1'b1;
    endtask

    task automatic do_err();
        VALID = 1'b1; LOAD = 1'b1; STORE = 1'b1; DATA_IN = $urandom;
        @(negedge CLK);
        chk("err_pulse", 32'(ERR), 32'd1);
        chk("err_no_ack", 32'(ACK_ADDR), 32'd0);
        chk("err_ready", 32'(READY), 32'd0);
        VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0;
        @(negedge CLK);
        chk("err_one_cycle", 32'(ERR), 32'd0);
        chk("err_ready_after", 32'(READY), 32'd0);
    endtask

    task automatic do_valid_only();
        VALID = 1'b1; LOAD = 1'b0; STORE = 1'b0; DATA_IN = $urandom;
        @(negedge CLK);
        VALID = 1'b0;
        chk("vo_ack_addr", 32'(ACK_ADDR), 32'd0);
        chk("vo_err", 32'(ERR), 32'd0);
        chk("vo_ackmem", 32'(ACK_DATA_MEM), 32'd0);
    endtask

    initial begin
        int op, line;
        logic [127:0] d;
        repeat (3) @(negedge CLK);
        chk("reset_ready", 32'(READY), 32'd0);
        chk("reset_oe", 32'(DATA_OE), 32'd0);
        chk("reset_data", DATA_OUT, 32'd0);
        chk("reset_ack_addr", 32'(ACK_ADDR), 32'd0);
        chk("reset_ackmem", 32'(ACK_DATA_MEM), 32'd0);
        chk("reset_err", 32'(ERR), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        do_store(32'h20, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        do_load(32'h20, 0, -1);
        do_load(32'h20, 2, -1);
        do_store(32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
        do_load(32'h40, 0, -1);
        do_err();
        do_load(32'h20, 0, -1);
        do_valid_only();
        do_load(32'h28, 0, -1);
        do_load(32'h20, 0, 2);
        do_load(32'h20, 0, -1);
        // top line of the store, reached through an aliased address
        do_store(32'h0000_0FF0, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 1'b0);
        do_load(32'h0001_3FF4, 0, -1);

        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 9));
            line = int'($urandom_range(0, 15));
            if (op < 4) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                do_store(rand_addr(line), d, 1'b1);
            end else if (op < 8) begin
                if (!line_valid[line]) line = 2;
                do_load(rand_addr(line), 1, -1);
            end else if (op == 8) begin
                do_err();
            end else begin
                do_valid_only();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
